// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its controller.
// The master modport is the datapath side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             MemRead_ID_EX;
  logic [REG_W-1:0] WriteReg_ID_EX;
  logic [REG_W-1:0] Rs_IF_ID;
  logic [REG_W-1:0] Rt_IF_ID;
  logic             BranchTaken_EX_MEM;
  logic             Jump_EX_MEM;
  logic             MemAccess_EX_MEM;
  logic             MemReady;

  logic             Enable_PC;
  logic             Enable_IF_ID;
  logic             Enable_ID_EX;
  logic             Enable_EX_MEM;
  logic             Enable_MEM_WB;
  logic             Flush_IF_ID;
  logic             Flush_ID_EX;
  logic             Flush_EX_MEM;
  logic             Bubble_MEM_WB;
  logic             Redirect;
  logic             MemError;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output MemRead_ID_EX, WriteReg_ID_EX, Rs_IF_ID, Rt_IF_ID,
           BranchTaken_EX_MEM, Jump_EX_MEM, MemAccess_EX_MEM, MemReady,
    input  Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB,
           Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, Bubble_MEM_WB, Redirect,
           MemError, StallCount, FlushCount
  );

  modport slave (
    input  MemRead_ID_EX, WriteReg_ID_EX, Rs_IF_ID, Rt_IF_ID,
           BranchTaken_EX_MEM, Jump_EX_MEM, MemAccess_EX_MEM, MemReady,
    output Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB,
           Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, Bubble_MEM_WB, Redirect,
           MemError, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, MEM-stage
// redirects and variable-latency data memory freezes with a halting timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_error_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              set_error, stall_inc, flush_inc;

  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic fl_if_id, fl_id_ex, fl_ex_mem, bubble, redirect;

  logic redirect_req, mem_busy, load_use;

  assign redirect_req = hz.BranchTaken_EX_MEM | hz.Jump_EX_MEM;
  assign mem_busy     = hz.MemAccess_EX_MEM & ~hz.MemReady;
  assign load_use     = hz.MemRead_ID_EX && (hz.WriteReg_ID_EX != REG_W'(0)) &&
                        ((hz.WriteReg_ID_EX == hz.Rs_IF_ID) ||
                         (hz.WriteReg_ID_EX == hz.Rt_IF_ID));

  // Next-state and pipeline control decode
  always_comb begin
    en_pc        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    en_mem_wb    = 1'b1;
    fl_if_id     = 1'b0;
    fl_id_ex     = 1'b0;
    fl_ex_mem    = 1'b0;
    bubble       = 1'b0;
    redirect     = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_error    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    unique case (state)
      RUN: begin
        if (redirect_req) begin
          redirect  = 1'b1;
          fl_if_id  = 1'b1;
          fl_id_ex  = 1'b1;
          fl_ex_mem = 1'b1;
          flush_inc = 1'b1;
        end else if (mem_busy) begin
          en_pc        = 1'b0;
          en_if_id     = 1'b0;
          en_id_ex     = 1'b0;
          en_ex_mem    = 1'b0;
          bubble       = 1'b1;
          wait_cnt_nxt = WAIT_W'(1);
          stall_inc    = 1'b1;
          state_nxt    = MEM_WAIT;
        end else if (load_use) begin
          en_pc     = 1'b0;
          en_if_id  = 1'b0;
          fl_id_ex  = 1'b1;
          stall_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Control-flow and load-use requests are held off until memory completes.
        if (hz.MemReady) begin
          state_nxt = RUN;
        end else begin
          en_pc     = 1'b0;
          en_if_id  = 1'b0;
          en_id_ex  = 1'b0;
          en_ex_mem = 1'b0;
          bubble    = 1'b1;
          stall_inc = 1'b1;
          if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            state_nxt = HALT;
            set_error = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      HALT: begin
        en_pc     = 1'b0;
        en_if_id  = 1'b0;
        en_id_ex  = 1'b0;
        en_ex_mem = 1'b0;
        en_mem_wb = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and statistics, clocked with the pipeline registers on the falling edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_error) begin
        mem_error_q <= 1'b1;
      end
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset overrides the decoded controls so every register holds while reset is low
  assign hz.Enable_PC     = reset & en_pc;
  assign hz.Enable_IF_ID  = reset & en_if_id;
  assign hz.Enable_ID_EX  = reset & en_id_ex;
  assign hz.Enable_EX_MEM = reset & en_ex_mem;
  assign hz.Enable_MEM_WB = reset & en_mem_wb;
  assign hz.Flush_IF_ID   = reset & fl_if_id;
  assign hz.Flush_ID_EX   = reset & fl_id_ex;
  assign hz.Flush_EX_MEM  = reset & fl_ex_mem;
  assign hz.Bubble_MEM_WB = reset & bubble;
  assign hz.Redirect      = reset & redirect;
  assign hz.MemError      = mem_error_q;
  assign hz.StallCount    = stall_cnt_q;
  assign hz.FlushCount    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4; control outputs are
// checked mid-cycle, counters just after the falling edge.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // {Enables PC..MEM_WB, Flush IF_ID/ID_EX/EX_MEM, Bubble, Redirect}
  logic [9:0] ctl;
  assign ctl = {hz.Enable_PC, hz.Enable_IF_ID, hz.Enable_ID_EX, hz.Enable_EX_MEM,
                hz.Enable_MEM_WB, hz.Flush_IF_ID, hz.Flush_ID_EX, hz.Flush_EX_MEM,
                hz.Bubble_MEM_WB, hz.Redirect};

  localparam logic [9:0] C_ZERO   = 10'b00000_00000;
  localparam logic [9:0] C_DEF    = 10'b11111_00000;
  localparam logic [9:0] C_REDIR  = 10'b11111_11101;
  localparam logic [9:0] C_FREEZE = 10'b00001_00010;
  localparam logic [9:0] C_LDUSE  = 10'b00111_01000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt, input logic jp,
                       input logic ma, input logic rdy);
    hz.MemRead_ID_EX      = mr;
    hz.WriteReg_ID_EX     = wr;
    hz.Rs_IF_ID           = rs;
    hz.Rt_IF_ID           = rt;
    hz.BranchTaken_EX_MEM = bt;
    hz.Jump_EX_MEM        = jp;
    hz.MemAccess_EX_MEM   = ma;
    hz.MemReady           = rdy;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] st, input logic [15:0] fl,
                         input logic err);
    chk({tag, "_stall"}, 32'(hz.StallCount), 32'(st));
    chk({tag, "_flush"}, 32'(hz.FlushCount), 32'(fl));
    chk({tag, "_err"},   32'(hz.MemError),   32'(err));
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk_cnt("rst", 0, 0, 0);
    cyc();
    reset = 1'b1;
    #1;
    chk("rel_def", 32'(ctl), 32'(C_DEF));

    // Load-use on Rs, then the dependent instruction with a NOP in EX
    drive(1, 8, 8, 3, 0, 0, 0, 1);
    chk("lu_rs", 32'(ctl), 32'(C_LDUSE));
    cyc();
    chk_cnt("lu_rs", 1, 0, 0);
    drive(0, 0, 8, 3, 0, 0, 0, 1);
    chk("lu_after", 32'(ctl), 32'(C_DEF));
    cyc();
    chk("lu_after_stall", 32'(hz.StallCount), 32'(1));

    // Load-use on Rt
    drive(1, 9, 1, 9, 0, 0, 0, 1);
    chk("lu_rt", 32'(ctl), 32'(C_LDUSE));
    cyc();
    chk("lu_rt_stall", 32'(hz.StallCount), 32'(2));

    // Load writing $0 never stalls
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("lu_r0", 32'(ctl), 32'(C_DEF));
    cyc();
    chk("lu_r0_stall", 32'(hz.StallCount), 32'(2));

    // Taken branch, then jump
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    chk("beq", 32'(ctl), 32'(C_REDIR));
    cyc();
    chk_cnt("beq", 2, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    chk("jump", 32'(ctl), 32'(C_REDIR));
    cyc();
    chk_cnt("jump", 2, 2, 0);

    // Memory wait: 3 not-ready cycles, branch ignored while waiting
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mw1", 32'(ctl), 32'(C_FREEZE));
    cyc();
    chk("mw1_stall", 32'(hz.StallCount), 32'(3));
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    chk("mw2_br_ignored", 32'(ctl), 32'(C_FREEZE));
    cyc();
    chk_cnt("mw2", 4, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mw3", 32'(ctl), 32'(C_FREEZE));
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("mw_ready", 32'(ctl), 32'(C_DEF));
    cyc();
    chk_cnt("mw_done", 5, 2, 0);
    drive(1, 8, 8, 0, 0, 0, 0, 1);
    chk("mw_back_run", 32'(ctl), 32'(C_LDUSE));
    cyc();
    chk("mw_back_stall", 32'(hz.StallCount), 32'(6));

    // Timeout: five frozen cycles with TIMEOUT=4 then HALT
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_frz%0d", i + 1), 32'(ctl), 32'(C_FREEZE));
      cyc();
      chk($sformatf("to_err%0d", i + 1), 32'(hz.MemError), (i == 4) ? 32'(1) : 32'(0));
    end
    chk("to_stall", 32'(hz.StallCount), 32'(11));
    chk("halt_ctl", 32'(ctl), 32'(C_ZERO));
    drive(1, 8, 8, 0, 1, 0, 1, 1);
    chk("halt_sticky", 32'(ctl), 32'(C_ZERO));
    cyc();
    chk("halt_hold", 32'(ctl), 32'(C_ZERO));
    chk_cnt("halt", 11, 2, 1);

    // Reset out of HALT
    reset = 1'b0;
    #1;
    chk("halt_rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk_cnt("halt_rst", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    chk("halt_rel", 32'(ctl), 32'(C_DEF));
    cyc();

    // Priority: redirect beats memory wait beats load-use
    drive(1, 8, 8, 0, 1, 0, 1, 0);
    chk("prio_redir", 32'(ctl), 32'(C_REDIR));
    cyc();
    chk_cnt("prio_redir", 0, 1, 0);
    drive(1, 8, 8, 0, 0, 0, 1, 0);
    chk("prio_mem", 32'(ctl), 32'(C_FREEZE));
    cyc();
    chk("prio_mem_stall", 32'(hz.StallCount), 32'(1));

    // Reset mid-MEM_WAIT
    reset = 1'b0;
    #1;
    chk("mwrst_ctl", 32'(ctl), 32'(C_ZERO));
    chk_cnt("mwrst", 0, 0, 0);
    drive(1, 8, 8, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    chk("mwrst_run", 32'(ctl), 32'(C_LDUSE));
    cyc();
    chk("mwrst_stall", 32'(hz.StallCount), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
